// File: rtl/aoc_bcd_pkg.sv
// rtl/aoc_bcd_pkg.sv - shared types and helpers for the BCD candidate generator
package aoc_bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t DIGIT_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gen_state_t;

  // Non-decimal nibbles are pinned to 9 so downstream compares stay in decimal order.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > DIGIT_MAX) ? DIGIT_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_inc.sv
// rtl/bcd_digit_inc.sv - one BCD digit of the ripple incrementer with monotonic fill
module bcd_digit_inc
  import aoc_bcd_pkg::*;
(
  input  bcd_digit_t digit_in,
  input  logic       carry_in,
  input  bcd_digit_t floor_in,
  output bcd_digit_t digit_out,
  output logic       carry_out
);

  logic at_max;

  assign at_max    = (digit_in >= DIGIT_MAX);
  assign carry_out = carry_in & at_max;

  // A wrapping digit takes floor_in rather than 0 so the string stays non-decreasing.
  always_comb begin
    digit_out = digit_in;
    if (carry_in) begin
      if (at_max) digit_out = floor_in;
      else        digit_out = digit_in + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_candidate_gen.sv
// rtl/bcd_candidate_gen.sv - streams packed BCD candidates across an inclusive range
module bcd_candidate_gen
  import aoc_bcd_pkg::*;
#(
  parameter int DIGITS         = 6,
  parameter int SKIP_MONOTONIC = 1,
  parameter int CNT_W          = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   range_lo,
  input  logic [4*DIGITS-1:0]   range_hi,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   cand,
  output logic [8*DIGITS-1:0]   cand_bytes,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      emit_count
);

  gen_state_t              state;
  logic [4*DIGITS-1:0]     cand_q;
  logic [4*DIGITS-1:0]     hi_q;
  logic [4*DIGITS-1:0]     norm_lo;
  logic [4*DIGITS-1:0]     next_cand;
  logic                    msd_carry;
  logic                    handshake;
  logic                    term;
  bcd_digit_t              nd;

  // Normalised lower bound: clamp, then ripple the running maximum from the MSD down.
  always_comb begin
    norm_lo = '0;
    nd      = bcd_clamp(range_lo[4*(DIGITS-1) +: 4]);
    norm_lo[4*(DIGITS-1) +: 4] = nd;
    for (int i = DIGITS - 2; i >= 0; i--) begin
      nd = bcd_clamp(range_lo[4*i +: 4]);
      if (SKIP_MONOTONIC != 0 && nd < norm_lo[4*(i+1) +: 4])
        nd = norm_lo[4*(i+1) +: 4];
      norm_lo[4*i +: 4] = nd;
    end
  end

  // Carry ripples up from digit 0, the fill floor ripples down from the MSD.
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    logic       c_in;
    logic       c_out;
    bcd_digit_t fl;
    bcd_digit_t d_out;

    if (i == 0) begin : g_c0
      assign c_in = 1'b1;
    end else begin : g_cn
      assign c_in = g_dig[i-1].c_out;
    end

    if (SKIP_MONOTONIC == 0 || i == DIGITS - 1) begin : g_f0
      assign fl = '0;
    end else begin : g_fn
      assign fl = g_dig[i+1].d_out;
    end

    bcd_digit_inc u_inc (
      .digit_in  (cand_q[4*i +: 4]),
      .carry_in  (c_in),
      .floor_in  (fl),
      .digit_out (d_out),
      .carry_out (c_out)
    );

    assign next_cand[4*i +: 4]  = d_out;
    assign cand_bytes[8*i +: 8] = {4'h0, cand_q[4*i +: 4]};
  end

  assign msd_carry = g_dig[DIGITS-1].c_out;
  assign handshake = out_valid & out_ready;
  assign term      = (cand_q == hi_q) | (next_cand > hi_q) | msd_carry;

  assign cand = cand_q;
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // In RUN, out_valid low means the bounds were just latched and still need the empty check.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cand_q     <= '0;
      hi_q       <= '0;
      out_valid  <= 1'b0;
      emit_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RUN;
            cand_q     <= norm_lo;
            hi_q       <= range_hi;
            emit_count <= '0;
            out_valid  <= 1'b0;
          end
        end
        RUN: begin
          if (!out_valid) begin
            if (cand_q > hi_q) state     <= DONE;
            else               out_valid <= 1'b1;
          end else if (handshake) begin
            if (emit_count != '1) emit_count <= emit_count + CNT_W'(1);
            if (term) begin
              out_valid <= 1'b0;
              state     <= DONE;
            end else begin
              cand_q <= next_cand;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_candidate_gen.sv
// tb/tb_bcd_candidate_gen.sv - directed bench for bcd_candidate_gen
module tb_bcd_candidate_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic [23:0] range_lo = '0;
  logic [23:0] range_hi = '0;
  logic        out_ready = 1'b0;

  logic        v0, busy0, done0;
  logic [23:0] c0;
  logic [47:0] cb0;
  logic [19:0] ec0;
  logic        v1, busy1, done1;
  logic [23:0] c1;
  logic [47:0] cb1;
  logic [19:0] ec1;

  int tests  = 0;
  int failed = 0;
  bit sel    = 1'b0;
  logic [23:0] got[$];
  logic [23:0] exp_q[$];

  always #5 clk = ~clk;

  bcd_candidate_gen #(.DIGITS(6), .SKIP_MONOTONIC(0), .CNT_W(20)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .range_lo(range_lo), .range_hi(range_hi),
    .out_valid(v0), .out_ready(out_ready), .cand(c0), .cand_bytes(cb0),
    .busy(busy0), .done(done0), .emit_count(ec0)
  );

  bcd_candidate_gen #(.DIGITS(6), .SKIP_MONOTONIC(1), .CNT_W(20)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .range_lo(range_lo), .range_hi(range_hi),
    .out_valid(v1), .out_ready(out_ready), .cand(c1), .cand_bytes(cb1),
    .busy(busy1), .done(done1), .emit_count(ec1)
  );

  function automatic logic cur_valid();
    return sel ? v1 : v0;
  endfunction
  function automatic logic cur_done();
    return sel ? done1 : done0;
  endfunction
  function automatic logic [23:0] cur_cand();
    return sel ? c1 : c0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit s, input logic [23:0] lo, input logic [23:0] hi);
    sel      = s;
    range_lo = lo;
    range_hi = hi;
    if (s) start1 = 1'b1; else start0 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic collect(input int budget, output int cycles);
    got.delete();
    cycles = 0;
    while (!cur_done() && cycles < budget) begin
      if (cur_valid() && out_ready) got.push_back(cur_cand());
      tick();
      cycles++;
    end
    tests++;
    if (cur_done() !== 1'b1) begin
      failed++;
      $display("FAIL collect_timeout: done=%0b required 1", cur_done());
    end
  endtask

  task automatic compare_list(input string name);
    tests++;
    if (got.size() != exp_q.size()) begin
      failed++;
      $display("FAIL %s_len: got %0d candidates required %0d", name, got.size(), exp_q.size());
    end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      tests++;
      if (got[k] !== exp_q[k]) begin
        failed++;
        $display("FAIL %s_item%0d: got %h required %h", name, k, got[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    tests++;
    if ({v0, busy0, done0, c0, ec0} !== '0) begin
      failed++;
      $display("FAIL reset_dut0: v=%0b busy=%0b done=%0b cand=%h cnt=%0d required all 0", v0, busy0, done0, c0, ec0);
    end
    tests++;
    if ({v1, busy1, done1, c1, ec1} !== '0) begin
      failed++;
      $display("FAIL reset_dut1: v=%0b busy=%0b done=%0b cand=%h cnt=%0d required all 0", v1, busy1, done1, c1, ec1);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_plain_count();
    int cyc;
    out_ready = 1'b1;
    do_start(1'b0, 24'h111110, 24'h111115);
    tests++;
    if (v0 !== 1'b0 || busy0 !== 1'b1) begin
      failed++;
      $display("FAIL t1_latency: valid=%0b busy=%0b required valid 0 busy 1", v0, busy0);
    end
    tick();
    tests++;
    if (cb0 !== 48'h010101010100) begin
      failed++;
      $display("FAIL t1_cand_bytes: got %h required 010101010100", cb0);
    end
    exp_q.delete();
    for (int d = 0; d <= 5; d++) exp_q.push_back(24'h111110 | 24'(d));
    collect(40, cyc);
    compare_list("t1");
    tests++;
    if (cyc != 6) begin
      failed++;
      $display("FAIL t1_cycles: got %0d required 6", cyc);
    end
    tests++;
    if (ec0 !== 20'd6 || v0 !== 1'b0 || busy0 !== 1'b0) begin
      failed++;
      $display("FAIL t1_end: cnt=%0d valid=%0b busy=%0b required 6 0 0", ec0, v0, busy0);
    end
  endtask

  task automatic test_monotonic();
    int cyc;
    out_ready = 1'b1;
    do_start(1'b1, 24'h123400, 24'h123460);
    tick();
    tests++;
    if (v1 !== 1'b1 || c1 !== 24'h123444) begin
      failed++;
      $display("FAIL t2_first: valid=%0b cand=%h required 1 123444", v1, c1);
    end
    exp_q.delete();
    for (int d = 4; d <= 9; d++) exp_q.push_back(24'h123440 | 24'(d));
    for (int d = 5; d <= 9; d++) exp_q.push_back(24'h123450 | 24'(d));
    collect(60, cyc);
    compare_list("t2");
    tests++;
    if (ec1 !== 20'd11) begin
      failed++;
      $display("FAIL t2_count: got %0d required 11", ec1);
    end
  endtask

  task automatic test_top_end();
    int cyc;
    bit zero_seen;
    out_ready = 1'b1;
    do_start(1'b0, 24'h999998, 24'h999999);
    exp_q.delete();
    exp_q.push_back(24'h999998);
    exp_q.push_back(24'h999999);
    collect(20, cyc);
    compare_list("t3");
    zero_seen = 1'b0;
    foreach (got[k]) if (got[k] == 24'h000000) zero_seen = 1'b1;
    tests++;
    if (zero_seen || ec0 !== 20'd2) begin
      failed++;
      $display("FAIL t3_wrap: zero_seen=%0b cnt=%0d required 0 2", zero_seen, ec0);
    end
  endtask

  task automatic test_empty_range();
    out_ready = 1'b1;
    do_start(1'b0, 24'h200000, 24'h100000);
    tests++;
    if (v0 !== 1'b0 || done0 !== 1'b0 || ec0 !== 20'd0) begin
      failed++;
      $display("FAIL t4_first: valid=%0b done=%0b cnt=%0d required 0 0 0", v0, done0, ec0);
    end
    tick();
    tests++;
    if (v0 !== 1'b0 || done0 !== 1'b1 || ec0 !== 20'd0 || busy0 !== 1'b0) begin
      failed++;
      $display("FAIL t4_done: valid=%0b done=%0b busy=%0b cnt=%0d required 0 1 0 0", v0, done0, busy0, ec0);
    end
  endtask

  task automatic test_back_pressure();
    int cyc;
    out_ready = 1'b0;
    do_start(1'b0, 24'h111110, 24'h111115);
    tick();
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (v0 !== 1'b1 || c0 !== 24'h111110) begin
        failed++;
        $display("FAIL t5_hold%0d: valid=%0b cand=%h required 1 111110", k, v0, c0);
      end
      tick();
    end
    out_ready = 1'b1;
    exp_q.delete();
    for (int d = 0; d <= 5; d++) exp_q.push_back(24'h111110 | 24'(d));
    collect(40, cyc);
    compare_list("t5");
    tests++;
    if (ec0 !== 20'd6) begin
      failed++;
      $display("FAIL t5_count: got %0d required 6", ec0);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    out_ready = 1'b1;
    do_start(1'b0, 24'h111110, 24'h111115);
    tick();
    tick();
    tick();
    tests++;
    if (ec0 !== 20'd2 || c0 !== 24'h111112) begin
      failed++;
      $display("FAIL t6_pre: cnt=%0d cand=%h required 2 111112", ec0, c0);
    end
    rst = 1'b0;
    #1;
    tests++;
    if ({v0, busy0, done0, c0, ec0} !== '0) begin
      failed++;
      $display("FAIL t6_async: v=%0b busy=%0b done=%0b cand=%h cnt=%0d required all 0", v0, busy0, done0, c0, ec0);
    end
    #2;
    rst = 1'b1;
    tick();
    do_start(1'b0, 24'h111110, 24'h111115);
    exp_q.delete();
    for (int d = 0; d <= 5; d++) exp_q.push_back(24'h111110 | 24'(d));
    collect(40, cyc);
    compare_list("t6");
  endtask

  initial begin
    test_reset();
    test_plain_count();
    test_monotonic();
    test_top_end();
    test_empty_range();
    test_back_pressure();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
